// File: rtl/fb_txbuf_ctrl_pkg.sv
// Shared types and constants for the TX payload buffer controller.
//   - txbuf_state_e      : controller FSM states
//   - FB_TXBUF_OFS_W     : in-bank byte offset width
//   - FB_TXBUF_UCNT_W    : underrun counter width
//   - FB_TXBUF_UCNT_MAX  : saturation value of the underrun counter
package fb_txbuf_ctrl_pkg;

  localparam int unsigned FB_TXBUF_ADDR_W = 8;
  localparam int unsigned FB_TXBUF_OFS_W  = FB_TXBUF_ADDR_W - 1;
  localparam int unsigned FB_TXBUF_UCNT_W = 8;
  localparam logic [FB_TXBUF_UCNT_W-1:0] FB_TXBUF_UCNT_MAX = '1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant0 = 2'd1,
    StGrant1 = 2'd2,
    StFull   = 2'd3
  } txbuf_state_e;

endpackage

// File: rtl/fb_rr_arb2.sv
// Two-input round-robin arbiter.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : request vector {req1, req0}
//   advance_i    : a packet from owner_i has completed; update priority
//   owner_i      : requester that just completed its packet
//   gnt_o        : one-hot grant, combinational from req_i and the pointer
module fb_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  input  logic       owner_i,
  output logic [1:0] gnt_o
);

  // ptr_q == 0 favours req0, 1 favours req1.
  logic ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    // Favour whoever was not served last.
    if (advance_i) ptr_d = ~owner_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ptr_q <= 1'b0;
    else       ptr_q <= ptr_d;
  end

  always_comb begin
    gnt_o = 2'b00;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/fb_txbuf_ctrl.sv
// Ping-pong payload loader and port-A write arbiter for the TX dual-port RAM.
// Two requesters fill the bank fb_txmac is not reading; banks swap on a
// DataSoC rising edge only when a complete payload is waiting.
//   MTxClk, Reset           : TX clock, asynchronous active-high reset
//   Req{0,1}Valid/Ofs/Data/Last/Ready : per-requester byte handshake
//   DataSoC                 : level; rising edge = start of data frame
//   RamAddrA/RamDataA/RamWeA: registered port-A write
//   TxBankSel               : bank fb_txmac reads
//   BufReady                : fill bank holds a complete payload
//   LastOwner               : requester that filled the bank being read
//   UnderrunCnt             : saturating count of frames with no new payload
//   StateIdle/Grant0/Grant1/Full : one-hot FSM state for LEDs
module fb_txbuf_ctrl
  import fb_txbuf_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_TXBUF_ADDR_W,
  parameter int unsigned OFS_W  = FB_TXBUF_OFS_W,
  parameter int unsigned UCNT_W = FB_TXBUF_UCNT_W
) (
  input  logic              MTxClk,
  input  logic              Reset,
  input  logic              Req0Valid,
  input  logic [OFS_W-1:0]  Req0Ofs,
  input  logic [7:0]        Req0Data,
  input  logic              Req0Last,
  output logic              Req0Ready,
  input  logic              Req1Valid,
  input  logic [OFS_W-1:0]  Req1Ofs,
  input  logic [7:0]        Req1Data,
  input  logic              Req1Last,
  output logic              Req1Ready,
  input  logic              DataSoC,
  output logic [ADDR_W-1:0] RamAddrA,
  output logic [7:0]        RamDataA,
  output logic              RamWeA,
  output logic              TxBankSel,
  output logic              BufReady,
  output logic              LastOwner,
  output logic [UCNT_W-1:0] UnderrunCnt,
  output logic              StateIdle,
  output logic              StateGrant0,
  output logic              StateGrant1,
  output logic              StateFull
);

  txbuf_state_e state_q, state_d;

  logic              soc_q;
  logic              soc_edge;
  logic              bank_q, bank_d;
  logic              buf_ready_q, buf_ready_d;
  logic              owner_q, owner_d;
  logic              last_owner_q, last_owner_d;
  logic [UCNT_W-1:0] ucnt_q, ucnt_d;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;

  logic              accept;
  logic              advance;
  logic [1:0]        gnt;

  assign soc_edge = DataSoC & ~soc_q;

  fb_rr_arb2 u_arb (
    .clk_i     (MTxClk),
    .rst_i     (Reset),
    .req_i     ({Req1Valid, Req0Valid}),
    .advance_i (advance),
    .owner_i   (state_q == StGrant1),
    .gnt_o     (gnt)
  );

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    buf_ready_d  = buf_ready_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    data_d       = data_q;
    accept       = 1'b0;
    advance      = 1'b0;
    Req0Ready    = 1'b0;
    Req1Ready    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (gnt[0])      state_d = StGrant0;
        else if (gnt[1]) state_d = StGrant1;
      end
      StGrant0: begin
        Req0Ready = 1'b1;
        if (Req0Valid) begin
          accept = 1'b1;
          // Fill bank is always the one fb_txmac is not reading.
          addr_d = {~bank_q, Req0Ofs};
          data_d = Req0Data;
          if (Req0Last) begin
            state_d     = StFull;
            buf_ready_d = 1'b1;
            owner_d     = 1'b0;
            advance     = 1'b1;
          end
        end
      end
      StGrant1: begin
        Req1Ready = 1'b1;
        if (Req1Valid) begin
          accept = 1'b1;
          addr_d = {~bank_q, Req1Ofs};
          data_d = Req1Data;
          if (Req1Last) begin
            state_d     = StFull;
            buf_ready_d = 1'b1;
            owner_d     = 1'b1;
            advance     = 1'b1;
          end
        end
      end
      StFull: begin
        if (soc_edge && buf_ready_q) begin
          state_d      = StIdle;
          bank_d       = ~bank_q;
          buf_ready_d  = 1'b0;
          last_owner_d = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // An edge seen before BufReady is registered is an underrun, even if the
  // last byte lands in that same cycle; that payload waits for the next edge.
  always_comb begin
    ucnt_d = ucnt_q;
    if (soc_edge && !buf_ready_q && (ucnt_q != {UCNT_W{1'b1}})) ucnt_d = ucnt_q + 1'b1;
  end

  always_ff @(posedge MTxClk or posedge Reset) begin
    if (Reset) begin
      state_q      <= StIdle;
      soc_q        <= 1'b0;
      bank_q       <= 1'b0;
      buf_ready_q  <= 1'b0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b0;
      ucnt_q       <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      soc_q        <= DataSoC;
      bank_q       <= bank_d;
      buf_ready_q  <= buf_ready_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ucnt_q       <= ucnt_d;
      we_q         <= accept;
      addr_q       <= addr_d;
      data_q       <= data_d;
    end
  end

  assign RamAddrA    = addr_q;
  assign RamDataA    = data_q;
  assign RamWeA      = we_q;
  assign TxBankSel   = bank_q;
  assign BufReady    = buf_ready_q;
  assign LastOwner   = last_owner_q;
  assign UnderrunCnt = ucnt_q;
  assign StateIdle   = (state_q == StIdle);
  assign StateGrant0 = (state_q == StGrant0);
  assign StateGrant1 = (state_q == StGrant1);
  assign StateFull   = (state_q == StFull);

endmodule

// File: tb/tb_fb_txbuf_ctrl.sv
// Directed testbench for fb_txbuf_ctrl: a vector table for the basic
// fill/swap flow plus hand-written sequences for arbitration, underrun
// saturation, coincident Last/edge and asynchronous reset mid-fill.
module tb_fb_txbuf_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, l0, v1, l1, soc;
  logic [6:0] o0, o1;
  logic [7:0] d0, d1;
  logic       r0, r1, we, bank, bufr, lo;
  logic [7:0] addr, data, uc;
  logic       s_idle, s_g0, s_g1, s_full;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fb_txbuf_ctrl dut (
    .MTxClk      (clk),
    .Reset       (rst),
    .Req0Valid   (v0),
    .Req0Ofs     (o0),
    .Req0Data    (d0),
    .Req0Last    (l0),
    .Req0Ready   (r0),
    .Req1Valid   (v1),
    .Req1Ofs     (o1),
    .Req1Data    (d1),
    .Req1Last    (l1),
    .Req1Ready   (r1),
    .DataSoC     (soc),
    .RamAddrA    (addr),
    .RamDataA    (data),
    .RamWeA      (we),
    .TxBankSel   (bank),
    .BufReady    (bufr),
    .LastOwner   (lo),
    .UnderrunCnt (uc),
    .StateIdle   (s_idle),
    .StateGrant0 (s_g0),
    .StateGrant1 (s_g1),
    .StateFull   (s_full)
  );

  localparam logic [3:0] ST_IDLE = 4'b1000;
  localparam logic [3:0] ST_G0   = 4'b0100;
  localparam logic [3:0] ST_G1   = 4'b0010;
  localparam logic [3:0] ST_FULL = 4'b0001;

  typedef struct {
    logic       v0;
    logic [6:0] o0;
    logic [7:0] d0;
    logic       l0;
    logic       soc;
    logic       r0;
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
    logic       bank;
    logic       bufr;
    logic       lo;
    logic [3:0] st;
    logic [7:0] uc;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic v0_, logic [6:0] o0_, logic [7:0] d0_, logic l0_, logic soc_,
                              logic r0_, logic we_, logic [7:0] addr_, logic [7:0] data_,
                              logic bank_, logic bufr_, logic lo_, logic [3:0] st_,
                              logic [7:0] uc_);
    vec_t v;
    v.v0 = v0_; v.o0 = o0_; v.d0 = d0_; v.l0 = l0_; v.soc = soc_;
    v.r0 = r0_; v.we = we_; v.addr = addr_; v.data = data_;
    v.bank = bank_; v.bufr = bufr_; v.lo = lo_; v.st = st_; v.uc = uc_;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 1'b0; o0 = '0; d0 = '0; l0 = 1'b0;
    v1 = 1'b0; o1 = '0; d1 = '0; l1 = 1'b0;
    soc = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [3:0] st_now();
    return {s_idle, s_g0, s_g1, s_full};
  endfunction

  initial begin
    // Fill bank 1 (0x80..) from req0, swap, then refill bank 0 (0x00..).
    vecs[0]  = mk(1, 0, 8'hA0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 0, ST_G0,   0);
    vecs[1]  = mk(1, 0, 8'hA0, 0, 0, 1, 1, 8'h80, 8'hA0, 0, 0, 0, ST_G0,   0);
    vecs[2]  = mk(1, 1, 8'hA1, 0, 0, 1, 1, 8'h81, 8'hA1, 0, 0, 0, ST_G0,   0);
    vecs[3]  = mk(1, 2, 8'hA2, 0, 0, 1, 1, 8'h82, 8'hA2, 0, 0, 0, ST_G0,   0);
    vecs[4]  = mk(1, 3, 8'hA3, 1, 0, 0, 1, 8'h83, 8'hA3, 0, 1, 0, ST_FULL, 0);
    vecs[5]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h83, 8'hA3, 0, 1, 0, ST_FULL, 0);
    vecs[6]  = mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h83, 8'hA3, 1, 0, 0, ST_IDLE, 0);
    vecs[7]  = mk(1, 0, 8'hB0, 0, 1, 1, 0, 8'h83, 8'hA3, 1, 0, 0, ST_G0,   0);
    vecs[8]  = mk(1, 0, 8'hB0, 1, 1, 0, 1, 8'h00, 8'hB0, 1, 1, 0, ST_FULL, 0);
    vecs[9]  = mk(0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'hB0, 1, 1, 0, ST_FULL, 0);
    vecs[10] = mk(0, 0, 8'h00, 0, 1, 0, 0, 8'h00, 8'hB0, 0, 0, 0, ST_IDLE, 0);

    // Reset values
    do_reset();
    chk("rst_we", we, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data", data, 0);
    chk("rst_bank", bank, 0);
    chk("rst_bufr", bufr, 0);
    chk("rst_lo", lo, 0);
    chk("rst_uc", uc, 0);
    chk("rst_state", st_now(), ST_IDLE);
    chk("rst_ready", {r0, r1}, 0);

    foreach (vecs[i]) begin
      v0 = vecs[i].v0; o0 = vecs[i].o0; d0 = vecs[i].d0; l0 = vecs[i].l0;
      soc = vecs[i].soc;
      tick();
      chk($sformatf("v%0d_r0", i), r0, vecs[i].r0);
      chk($sformatf("v%0d_r1", i), r1, 0);
      chk($sformatf("v%0d_we", i), we, vecs[i].we);
      chk($sformatf("v%0d_addr", i), addr, vecs[i].addr);
      chk($sformatf("v%0d_data", i), data, vecs[i].data);
      chk($sformatf("v%0d_bank", i), bank, vecs[i].bank);
      chk($sformatf("v%0d_bufr", i), bufr, vecs[i].bufr);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_state", i), st_now(), vecs[i].st);
      chk($sformatf("v%0d_uc", i), uc, vecs[i].uc);
    end

    // Contention after reset: req0 wins, grant held across a Valid gap.
    do_reset();
    v0 = 1; o0 = 0; d0 = 8'h10; v1 = 1; o1 = 5; d1 = 8'h55;
    tick();
    chk("arb_first_r0", r0, 1);
    chk("arb_first_r1", r1, 0);
    tick();
    chk("arb_beat0_addr", addr, 8'h80);
    v0 = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("gap%0d_r1", i), r1, 0);
      chk($sformatf("gap%0d_state", i), st_now(), ST_G0);
      chk($sformatf("gap%0d_we", i), we, 0);
    end
    v0 = 1; o0 = 1; d0 = 8'h11; l0 = 1;
    tick();
    chk("arb_last_addr", addr, 8'h81);
    chk("arb_last_state", st_now(), ST_FULL);
    l0 = 0; o0 = 0; d0 = 8'h20; soc = 1;
    tick();
    chk("arb_swap_bank", bank, 1);
    chk("arb_swap_state", st_now(), ST_IDLE);
    soc = 0;
    tick();
    chk("arb_second_r1", r1, 1);
    chk("arb_second_r0", r0, 0);
    v0 = 0; l1 = 1;
    tick();
    chk("arb_r1_we", we, 1);
    chk("arb_r1_addr", addr, 8'h05);
    chk("arb_r1_data", data, 8'h55);
    chk("arb_r1_state", st_now(), ST_FULL);
    v1 = 0; l1 = 0; soc = 1;
    tick();
    chk("arb_r1_swap_bank", bank, 0);
    chk("arb_r1_lastowner", lo, 1);

    // Underrun saturation: 300 edges with no payload.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      soc = 1;
      tick();
      soc = 0;
      tick();
      if (i == 0) chk("ur_first", uc, 1);
      if (i == 254) chk("ur_255", uc, 255);
    end
    chk("ur_sat", uc, 255);
    chk("ur_bank", bank, 0);
    chk("ur_state", st_now(), ST_IDLE);

    // Last accepted in the same cycle as an edge: underrun, swap deferred.
    do_reset();
    v0 = 1; o0 = 0; d0 = 8'hC0; l0 = 1;
    tick();
    chk("coin_grant", st_now(), ST_G0);
    soc = 1;
    tick();
    chk("coin_uc", uc, 1);
    chk("coin_bank", bank, 0);
    chk("coin_bufr", bufr, 1);
    chk("coin_addr", addr, 8'h80);
    v0 = 0; l0 = 0; soc = 0;
    tick();
    soc = 1;
    tick();
    chk("coin_swap_bank", bank, 1);
    chk("coin_swap_uc", uc, 1);
    chk("coin_swap_bufr", bufr, 0);

    // Asynchronous reset mid-fill (bank 1 displayed, so fill goes to 0x00..).
    soc = 0; v0 = 1; o0 = 0; d0 = 8'hD0;
    tick();
    tick();
    o0 = 1; d0 = 8'hD1;
    tick();
    chk("mid_addr", addr, 8'h01);
    chk("mid_data", data, 8'hD1);
    o0 = 2; d0 = 8'hD2;
    #2;
    rst = 1;
    #1;
    chk("ar_we", we, 0);
    chk("ar_addr", addr, 0);
    chk("ar_data", data, 0);
    chk("ar_bank", bank, 0);
    chk("ar_uc", uc, 0);
    chk("ar_state", st_now(), ST_IDLE);
    chk("ar_r0", r0, 0);
    idle_inputs();
    @(negedge clk);
    rst = 0;
    v0 = 1; o0 = 0; v1 = 1;
    tick();
    chk("ar_regrant_r0", r0, 1);
    chk("ar_regrant_r1", r1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
